// File: rtl/mvm_pkg.sv
// Shared definitions for the 8x8 matrix-vector MAC engine, its loader and benches.
//   ldr_state_t : loader FSM state encoding
//   N_ROWS      : number of A FIFOs (matrix rows)
//   N_COLS      : elements per row, also the B vector length
//   JOB_BYTES   : bytes in one job stream (matrix then vector)
//   IDX_W       : width of the row/col/vector index counters
package mvm_pkg;

  localparam int unsigned N_ROWS    = 8;
  localparam int unsigned N_COLS    = 8;
  localparam int unsigned JOB_BYTES = N_ROWS * N_COLS + N_COLS;
  localparam int unsigned IDX_W     = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD_A,
    LOAD_B,
    FIN
  } ldr_state_t;

endpackage

// File: rtl/mat_vec_loader.sv
// Write-side front end of the 8x8 matrix-vector MAC engine. Accepts one 72-byte job
// (64 row-major matrix bytes, then 8 vector bytes) on a valid/ready stream and steers
// each byte into its per-row A FIFO or the B vector FIFO through a registered write stage.
//   clk, rst              : clock, synchronous active-high reset
//   start                 : job request, honoured only in IDLE with all FIFOs empty
//   in_data/valid/last    : input stream; in_last marks the 72nd byte
//   in_ready              : high in LOAD_A/LOAD_B
//   a_empty, b_empty      : FIFO empty flags, gate job start
//   a_wren, a_fifo_in     : per-row A FIFO write port (one cycle after the handshake)
//   b_wren, b_fifo_in     : B FIFO write port (one cycle after the handshake)
//   Clr                   : one-cycle accumulator clear before loading
//   busy                  : state != IDLE
//   done                  : one-cycle pulse in FIN, coincident with the last B write
//   err                   : sticky framing error for the current job
module mat_vec_loader
  import mvm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  a_empty   [N_ROWS-1:0],
  input  logic                  b_empty,
  output logic                  a_wren    [N_ROWS-1:0],
  output logic [DATA_WIDTH-1:0] a_fifo_in [N_ROWS-1:0],
  output logic                  b_wren,
  output logic [DATA_WIDTH-1:0] b_fifo_in,
  output logic                  Clr,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(N_ROWS - 1);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(N_COLS - 1);
  // A FIFO shallower than one row/vector could overflow; such a loader never starts.
  localparam bit DEPTH_OK = (DEPTH >= N_COLS);

  ldr_state_t            r_state;
  logic [IDX_W-1:0]      r_row;
  logic [IDX_W-1:0]      r_col;
  logic [IDX_W-1:0]      r_bidx;
  logic                  r_err;
  logic                  r_a_wren [N_ROWS-1:0];
  logic [DATA_WIDTH-1:0] r_a_data [N_ROWS-1:0];
  logic                  r_b_wren;
  logic [DATA_WIDTH-1:0] r_b_data;

  logic w_all_empty;
  logic w_hs;
  logic w_last_byte;
  logic w_frame_bad;

  always_comb begin
    w_all_empty = b_empty;
    for (int i = 0; i < N_ROWS; i++) begin
      w_all_empty = w_all_empty & a_empty[i];
    end
  end

  assign in_ready    = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign w_hs        = in_valid & in_ready;
  assign w_last_byte = (r_state == LOAD_B) && (r_bidx == LAST_COL);
  // in_last must coincide exactly with the 72nd handshake
  assign w_frame_bad = w_hs & (in_last != w_last_byte);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_bidx   <= '0;
      r_err    <= 1'b0;
      r_b_wren <= 1'b0;
      r_b_data <= '0;
      for (int i = 0; i < N_ROWS; i++) begin
        r_a_wren[i] <= 1'b0;
        r_a_data[i] <= '0;
      end
    end else begin
      // write enables are single-cycle; data registers hold between writes
      r_b_wren <= 1'b0;
      for (int i = 0; i < N_ROWS; i++) begin
        r_a_wren[i] <= 1'b0;
      end
      if (w_frame_bad) begin
        r_err <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (start && w_all_empty && DEPTH_OK) begin
            r_state <= CLR;
            r_err   <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_bidx  <= '0;
          end
        end
        CLR: r_state <= LOAD_A;
        LOAD_A: begin
          if (w_hs) begin
            r_a_wren[r_row] <= 1'b1;
            r_a_data[r_row] <= in_data;
            r_col           <= r_col + 1'b1;
            if (r_col == LAST_COL) begin
              r_row <= r_row + 1'b1;
              if (r_row == LAST_ROW) begin
                r_state <= LOAD_B;
              end
            end
          end
        end
        LOAD_B: begin
          if (w_hs) begin
            r_b_wren <= 1'b1;
            r_b_data <= in_data;
            r_bidx   <= r_bidx + 1'b1;
            if (r_bidx == LAST_COL) begin
              r_state <= FIN;
            end
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign a_wren    = r_a_wren;
  assign a_fifo_in = r_a_data;
  assign b_wren    = r_b_wren;
  assign b_fifo_in = r_b_data;
  assign Clr       = (r_state == CLR);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FIN);
  assign err       = r_err;

endmodule

// File: tb/tb_mat_vec_loader.sv
module tb_mat_vec_loader;
  import mvm_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       a_empty   [N_ROWS-1:0];
  logic       b_empty;
  logic       a_wren    [N_ROWS-1:0];
  logic [7:0] a_fifo_in [N_ROWS-1:0];
  logic       b_wren;
  logic [7:0] b_fifo_in;
  logic       Clr;
  logic       busy;
  logic       done;
  logic       err;

  mat_vec_loader #(
    .DATA_WIDTH(8),
    .DEPTH     (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .a_empty  (a_empty),
    .b_empty  (b_empty),
    .a_wren   (a_wren),
    .a_fifo_in(a_fifo_in),
    .b_wren   (b_wren),
    .b_fifo_in(b_fifo_in),
    .Clr      (Clr),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Job vector: stream shape in, expected timing/flags out. Offsets are cycles after
  // the cycle in which start is presented.
  typedef struct {
    string name;
    int    stall0;      // byte index after which in_valid drops for 3 cycles (-1 none)
    int    stall1;
    int    stall2;
    int    last_pos;    // byte index carrying in_last
    int    busy_start;  // byte index presented together with a start pulse (-1 none)
    int    exp_done;    // done cycle offset
    int    exp_err;     // err at end of job
    int    exp_err_cyc; // first cycle offset with err=1 (-1 never)
  } job_t;

  int n_cmp = 0;
  int n_err = 0;
  int cnt   = 0;
  int c0;

  // monitor logs
  int log_kind[$];
  int log_data[$];
  int multi_hot;
  int clr_cnt, clr_cyc, clr_err;
  int done_cnt, done_cyc, last_b_cyc, err_cyc;

  always @(posedge clk) cnt <= cnt + 1;

  always @(negedge clk) begin
    int hot;
    hot = 0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (a_wren[r]) begin
        hot++;
        log_kind.push_back(r);
        log_data.push_back(int'(a_fifo_in[r]));
      end
    end
    if (hot > 1) multi_hot++;
    if (b_wren) begin
      log_kind.push_back(8);
      log_data.push_back(int'(b_fifo_in));
      last_b_cyc = cnt;
    end
    if (Clr) begin
      clr_cnt++;
      clr_cyc = cnt;
      clr_err = int'(err);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cnt;
    end
    if (err && err_cyc < 0 && clr_cnt > 0) err_cyc = cnt;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_kind.delete();
    log_data.delete();
    multi_hot  = 0;
    clr_cnt    = 0;
    clr_cyc    = -1;
    clr_err    = -1;
    done_cnt   = 0;
    done_cyc   = -1;
    last_b_cyc = -1;
    err_cyc    = -1;
  endtask

  function automatic int outputs_nonzero();
    int n;
    n = 0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (a_wren[r]) n++;
      if (a_fifo_in[r] != 8'd0) n++;
    end
    if (b_wren) n++;
    if (b_fifo_in != 8'd0) n++;
    if (Clr) n++;
    if (busy) n++;
    if (done) n++;
    if (err) n++;
    if (in_ready) n++;
    return n;
  endfunction

  // Expected write order: byte k goes to row k/8 for k<64, else to B.
  task automatic check_writes(input string name);
    int bad;
    bad = 0;
    check({name, "_write_count"}, log_kind.size(), JOB_BYTES);
    for (int i = 0; i < log_kind.size() && i < JOB_BYTES; i++) begin
      if (log_kind[i] != ((i < 64) ? i / 8 : 8) || log_data[i] != i) bad++;
    end
    check({name, "_write_seq_bad"}, bad, 0);
    check({name, "_multi_hot"}, multi_hot, 0);
  endtask

  task automatic run_job(input job_t j);
    int  k;
    int  guard;
    bit  took;
    clear_logs();
    start = 1'b1;
    c0    = cnt;
    tick();
    start = 1'b0;
    k     = 0;
    guard = 0;
    while (k < JOB_BYTES && guard < 400) begin
      in_valid = 1'b1;
      in_data  = k[7:0];
      in_last  = (k == j.last_pos);
      start    = (k == j.busy_start);
      took     = in_ready;
      tick();
      guard++;
      start = 1'b0;
      if (took) begin
        if (k == j.stall0 || k == j.stall1 || k == j.stall2) begin
          in_valid = 1'b0;
          repeat (3) tick();
        end
        k++;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({j.name, "_stream_accepted"}, k, JOB_BYTES);
    guard = 0;
    while (done_cnt == 0 && guard < 20) begin
      tick();
      guard++;
    end
    repeat (4) tick();
    check_writes(j.name);
    check({j.name, "_clr_count"}, clr_cnt, 1);
    check({j.name, "_clr_offset"}, clr_cyc - c0, 1);
    check({j.name, "_err_in_clr"}, clr_err, 0);
    check({j.name, "_done_count"}, done_cnt, 1);
    check({j.name, "_done_offset"}, done_cyc - c0, j.exp_done);
    check({j.name, "_last_b_with_done"}, last_b_cyc, done_cyc);
    check({j.name, "_err_final"}, int'(err), j.exp_err);
    check({j.name, "_err_rise"}, (err_cyc < 0) ? -1 : err_cyc - c0, j.exp_err_cyc);
    check({j.name, "_idle_after"}, int'(busy), 0);
  endtask

  job_t tbl[5];

  initial begin
    int k;
    int guard;
    bit took;

    tbl[0] = '{"basic",     -1, -1, -1, 71, -1, 74, 0, -1};
    tbl[1] = '{"stalled",    5, 63, 70, 71, -1, 83, 0, -1};
    tbl[2] = '{"framing",   -1, -1, -1, 10, -1, 74, 1, 13};
    tbl[3] = '{"clean",     -1, -1, -1, 71, -1, 74, 0, -1};
    tbl[4] = '{"busystart", -1, -1, -1, 71, 66, 74, 0, -1};

    rst      = 1'b1;
    start    = 1'b0;
    in_data  = 8'd0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    b_empty  = 1'b1;
    for (int r = 0; r < N_ROWS; r++) a_empty[r] = 1'b1;
    clear_logs();
    repeat (3) tick();
    check("reset_outputs_nonzero", outputs_nonzero(), 0);
    rst = 1'b0;
    tick();

    for (int t = 0; t < 5; t++) run_job(tbl[t]);

    // start with a non-empty A FIFO is ignored
    clear_logs();
    a_empty[3] = 1'b0;
    start      = 1'b1;
    repeat (3) tick();
    check("nonempty_busy", int'(busy), 0);
    check("nonempty_in_ready", int'(in_ready), 0);
    check("nonempty_clr_count", clr_cnt, 0);
    start      = 1'b0;
    a_empty[3] = 1'b1;
    tick();
    run_job(tbl[0]);

    // reset after 30 handshakes
    clear_logs();
    start = 1'b1;
    tick();
    start = 1'b0;
    k     = 0;
    guard = 0;
    while (k < 30 && guard < 100) begin
      in_valid = 1'b1;
      in_data  = k[7:0];
      in_last  = 1'b0;
      took     = in_ready;
      tick();
      guard++;
      if (took) k++;
    end
    check("midrst_accepted", k, 30);
    rst = 1'b1;
    tick();
    check("midrst_outputs_nonzero", outputs_nonzero(), 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (5) tick();
    check("midrst_write_count", log_kind.size(), 30);
    check("midrst_busy", int'(busy), 0);
    run_job(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mat_vec_loader.md
Name: mat_vec_loader

Overview:
- Write-side front end for the 8x8 matrix-vector MAC engine.
- Accepts one job as a 72-byte valid/ready stream: 64 matrix bytes in row-major order, then 8 vector bytes.
- Steers each byte into the correct per-row A FIFO (a_wren / a_fifo_in) or the B vector FIFO (b_wren / b_fifo_in).
- Pulses Clr to the MAC array before loading starts and pulses done after the final write.

Parameters:
- DATA_WIDTH, 8, width of each matrix/vector element and of every FIFO data port.
- DEPTH, 8, depth of each target FIFO; must be >= 8 (the loader writes exactly 8 entries per FIFO per job).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- in_data  in  DATA_WIDTH  stream byte.
- in_valid  in  1  stream byte valid.
- in_last  in  1  asserted by the source on the 72nd byte.
- in_ready  out  1  loader can accept in_data this cycle.
- a_empty  in  1 x8 (unpacked [7:0])  empty flags of the A FIFOs.
- b_empty  in  1  empty flag of the B FIFO.
- a_wren  out  1 x8 (unpacked [7:0])  A FIFO write enables; at most one high per cycle.
- a_fifo_in  out  DATA_WIDTH x8 (unpacked [7:0])  A FIFO write data.
- b_wren  out  1  B FIFO write enable.
- b_fifo_in  out  DATA_WIDTH  B FIFO write data.
- Clr  out  1  one-cycle accumulator clear to the MAC array.
- busy  out  1  high from leaving IDLE until return to IDLE.
- done  out  1  one-cycle pulse when the job's last write has been issued.
- err  out  1  sticky framing error for the current job.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; row, col and bidx counters = 0.
  - All of a_wren, b_wren, Clr, done, err, busy and in_ready = 0.
  - a_fifo_in[*] and b_fifo_in = 0.
  - Reset mid-job abandons the job; partially written FIFO contents are the system's responsibility.
- States: IDLE, CLR, LOAD_A, LOAD_B, FIN.
- IDLE:
  - in_ready=0.
  - If start=1 and all a_empty=1 and b_empty=1: go to CLR and clear err.
  - If start=1 while any FIFO is non-empty: start is ignored and the loader stays in IDLE.
- CLR: lasts exactly 1 cycle with Clr=1, then LOAD_A.
- LOAD_A:
  - in_ready=1. On a handshake (in_valid & in_ready), the byte goes to FIFO[row].
  - col increments; when col wraps 7->0, row increments.
  - The handshake on row=7, col=7 moves the loader to LOAD_B.
- LOAD_B:
  - in_ready=1. Each handshake writes the byte to the B FIFO and increments bidx.
  - The handshake on bidx=7 moves the loader to FIN.
- FIN: lasts 1 cycle with done=1, then IDLE.
- Write latency:
  - Write outputs are registered. A handshake in cycle N produces the wren/data pulse in cycle N+1.
  - wren is low in every cycle without a preceding handshake.
  - Data outputs hold their last value when wren=0.
- Timing consequences:
  - The last B write (b_wren) occurs in the FIN cycle, coincident with done.
  - A zero-bubble job is 1 CLR + 72 load cycles + 1 FIN = 74 cycles from the start sample to done.
- Backpressure: the loader never deasserts in_ready inside LOAD_A/LOAD_B. Overflow is impossible because start requires empty FIFOs and DEPTH >= 8.
- Stalls: in_valid=0 stalls the counters indefinitely; there is no timeout.
- Framing (err):
  - err sets if in_last=1 on any handshake other than the 72nd, or in_last=0 on the 72nd.
  - The job still runs to its full 72-byte count; there is no early exit.
  - err holds until the next accepted start or rst.
- start while busy is ignored.
- busy = (state != IDLE).

Decomposition:
- Shared package mvm_pkg:
  - state enum ldr_state_t {IDLE, CLR, LOAD_A, LOAD_B, FIN}.
  - localparams N_ROWS=8, N_COLS=8, JOB_BYTES=72.
  - These are shared with the engine and the bench.
- No sub-module. Counters, FSM and the registered write stage all live in one module.

Test Plan:
- Basic job:
  - rst, then start with all FIFOs empty; stream bytes 0..71 back-to-back, with in_last on byte 71.
  - Expect Clr for 1 cycle, then a_wren[r] pulses carrying r*8+c for c=0..7.
  - Then b_wren carrying 64..71; done in cycle 74 after start; err=0.
- Stalled stream: same data with in_valid deasserted for 3 cycles after bytes 5, 63 and 70 → identical write sequence; done delayed by 9 cycles.
- Non-empty start: a_empty[3]=0 while start=1 → remains IDLE, no Clr, in_ready=0. Release a_empty[3] and pulse start → normal job.
- Framing:
  - in_last=1 on byte 10 and 0 on byte 71 → err=1 from the cycle after byte 10; all 72 writes still occur; done pulses.
  - A following clean job clears err.
- Reset mid-job: rst=1 after 30 handshakes → next cycle IDLE, all outputs 0, no further wren. A new start runs from row 0, col 0.
- start during busy: pulse start in LOAD_B → no effect; only one done pulse.
